alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle shift-and-add multiplier sequencer that owns the shared 8-bit combinational `alu` while a multiply is running.
- When idle, the processor datapath's ALU request passes straight through to the `alu`.
- When busy, the sequencer drives the `alu` itself for WIDTH iterations and returns a 2×WIDTH product.
- Sits between the pico_mips decode/datapath and the `alu` instance.

Parameters:
- WIDTH, 8, operand width; must equal the `alu` data width.
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- multiplicand  in  WIDTH  operand A; captured on accepted start.
- multiplier  in  WIDTH  operand B; captured on accepted start.
- busy  out  1  high while sequencer owns the ALU (RUN and DONE).
- done  out  1  one-cycle pulse; product valid.
- product_hi  out  WIDTH  upper half of product; held until next accepted start.
- product_lo  out  WIDTH  lower half of product; held until next accepted start.
- cpu_alu_ctrl  in  1  datapath ALU op (0 = add, 1 = subtract input1−input2).
- cpu_input1  in  WIDTH  datapath ALU operand 1.
- cpu_input2  in  WIDTH  datapath ALU operand 2.
- alu_ctrl  out  1  to `alu`.
- alu_input1  out  WIDTH  to `alu`.
- alu_input2  out  WIDTH  to `alu`.
- alu_result  in  WIDTH  from `alu`; combinational, same cycle.

Behaviour:
- Reset (async, active-high): state = IDLE; busy = 0, done = 0, product_hi = 0, product_lo = 0; internal acc, mq, mcand and cnt cleared.
- States: IDLE → RUN → DONE → IDLE.
- IDLE:
  - ALU mux is pass-through: alu_ctrl = cpu_alu_ctrl, alu_input1 = cpu_input1, alu_input2 = cpu_input2.
  - On start = 1: load mcand = multiplicand, mq = multiplier, acc = 0, cnt = 0; go to RUN.
  - The captured operands are not used in the start cycle.
- RUN (exactly WIDTH cycles):
  - ALU drives: alu_ctrl = 0, alu_input1 = acc, alu_input2 = mcand.
  - If mq[0] = 1: sum = alu_result, carry = (alu_result < acc), unsigned compare.
  - If mq[0] = 0: sum = acc, carry = 0.
  - Same edge: {acc, mq} <= {carry, sum, mq} >> 1, right shift by one; cnt <= cnt + 1.
  - When cnt = WIDTH−1 the shift completes and the block goes to DONE.
- DONE (1 cycle):
  - done = 1, busy = 1.
  - product_hi = acc, product_lo = mq; both registered and held through IDLE.
  - ALU mux remains owned (ctrl 0, operands acc/mcand); the result is ignored.
  - Next state is IDLE.
- Latency: start accepted at edge N → done high in cycle N+WIDTH+1 (10 cycles for WIDTH = 8). The next start is accepted the cycle after DONE.
- busy is registered: high from the first RUN cycle through the DONE cycle. The datapath must stall while busy = 1; cpu_* inputs are ignored then.
- start while busy = 1, including during DONE: ignored, no queueing.
- start held high continuously: a new multiply is accepted every WIDTH+2 cycles.
- Operands change after acceptance: no effect on the running multiply.
- Reset asserted mid-RUN: immediate abort; all outputs return to reset values; no done pulse.
- Arithmetic:
  - Unsigned, no overflow possible.
  - 255×255 = 0xFE01; the carry bit catches acc wrap.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Operands are two's complement (Robertson's algorithm).
  - In iterations 0..WIDTH−2, when mq[0] = 1, add with alu_ctrl = 0.
  - In the final iteration, when mq[0] = 1, subtract with alu_ctrl = 1 (input1 = acc, input2 = mcand).
  - Shift-in bit = sum[WIDTH−1] XOR ovf, where:
    - add overflow: a[msb] == b[msb] && r[msb] != a[msb];
    - subtract overflow: a[msb] != b[msb] && r[msb] != a[msb];
    - when mq[0] = 0, the shift-in bit = acc[msb].
- Not defined: unsigned behaviour as above; alu_ctrl is never 1 during RUN.

Decomposition:
- Shared package pico_pkg holds:
  - alu_op_t enum (ALU_ADD = 1'b0, ALU_SUB = 1'b1);
  - mul_state_t enum (IDLE, RUN, DONE);
  - DATA_W = 8.
- No sub-module. The ALU mux and the control FSM stay in alu_mul_seq; the `alu` is instantiated alongside it by the parent, not inside.

Test Plan:
- Idle pass-through: ctrl = 0, input1 = 0x10, input2 = 0x20 → alu_input* mirror the inputs, alu_result = 0x30, busy = 0.
- Basic multiply: start with 13, 11 → busy high for 9 cycles; done at cycle 10 with product_hi = 0x00, product_lo = 0x8F.
- Carry and corners:
  - 255×255 → 0xFE01;
  - 0×200 → 0x0000;
  - 1×0x80 → 0x0080;
  - products stay held after done until the next start.
- Start while busy: second start pulses with new operands at RUN cycles 3 and 9 (DONE) → ignored; first product unchanged; exactly one done pulse.
- Reset mid-op: assert reset in RUN cycle 4 of 200×3 → busy, done and product go to 0 asynchronously; a following 200×3 gives 0x0258.
- With MUL_SIGNED_EN:
  - −3×5 → 0xFFF1;
  - −128×−128 → 0x4000;
  - 127×−1 → 0xFF81;
  - alu_ctrl = 1 observed only in the final RUN cycle, and only when mq[0] = 1.

Source files
------------

// File: rtl/pico_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : pico_pkg                                                   |
// | Shared pico_mips types: ALU opcode, multiplier FSM states, data width|
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package pico_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : pico_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_mul_seq                                                |
// | Shift-and-add multiplier that borrows the shared ALU while running.  |
// | Option  : MUL_SIGNED_EN selects two's complement (Robertson) mode.   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module alu_mul_seq
    import pico_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    input  logic             cpu_alu_ctrl,
    input  logic [WIDTH-1:0] cpu_input1,
    input  logic [WIDTH-1:0] cpu_input2,
    output logic             alu_ctrl,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] plo_q, plo_d;

    logic             w_last;
    alu_op_t          w_run_op;
    logic [WIDTH-1:0] w_sum;
    logic             w_shin;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_mq_nx;
`ifdef MUL_SIGNED_EN
    logic             w_ovf;
`endif

    assign w_last = (cnt_q == LAST_CNT);

    // Robertson: the multiplier sign bit carries negative weight, so the last partial product is subtracted
`ifdef MUL_SIGNED_EN
    assign w_run_op = (w_last && mq_q[0]) ? ALU_SUB : ALU_ADD;
`else
    assign w_run_op = ALU_ADD;
`endif

    always_comb begin
        if (state_q == IDLE) begin
            alu_ctrl   = cpu_alu_ctrl;
            alu_input1 = cpu_input1;
            alu_input2 = cpu_input2;
        end else begin
            alu_ctrl   = (state_q == RUN) ? w_run_op : ALU_ADD;
            alu_input1 = acc_q;
            alu_input2 = mcand_q;
        end
    end

    always_comb begin
        w_sum = mq_q[0] ? alu_result : acc_q;
`ifdef MUL_SIGNED_EN
        w_ovf  = 1'b0;
        w_shin = acc_q[WIDTH-1];
        if (mq_q[0]) begin
            if (w_run_op == ALU_SUB) begin
                w_ovf = (acc_q[WIDTH-1] != mcand_q[WIDTH-1]) && (alu_result[WIDTH-1] != acc_q[WIDTH-1]);
            end else begin
                w_ovf = (acc_q[WIDTH-1] == mcand_q[WIDTH-1]) && (alu_result[WIDTH-1] != acc_q[WIDTH-1]);
            end
            w_shin = alu_result[WIDTH-1] ^ w_ovf;
        end
`else
        // The ALU is only WIDTH bits wide; a wrapped sum is smaller than acc
        w_shin = mq_q[0] && (alu_result < acc_q);
`endif
        w_acc_nx = {w_shin, w_sum[WIDTH-1:1]};
        w_mq_nx  = {w_sum[0], mq_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mcand_d = multiplicand;
                    mq_d    = multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d = w_acc_nx;
                mq_d  = w_mq_nx;
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    phi_d   = w_acc_nx;
                    plo_d   = w_mq_nx;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_hi = phi_q;
    assign product_lo = plo_q;

endmodule : alu_mul_seq
`default_nettype wire
